// File: rtl/fetch_pc_gen_pkg.sv
// Shared front-end defines: control encodings, boot vector, fetch FSM states
// and the AdEL exception code.
package fetch_pc_gen_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic RstDisable  = 1'b0;
    localparam logic Stop        = 1'b1;
    localparam logic NoStop      = 1'b0;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    localparam logic [31:0] DefaultResetPc = 32'hbfc00000;

    // Address error on instruction fetch (load/fetch side)
    localparam logic [4:0] ExcAdel = 5'h04;

    typedef enum logic {
        RUN = 1'b0,
        ERR = 1'b1
    } pc_state_e;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// I-cache fetch-group request channel: the PC generator drives, the I-cache
// answers with req_ready.
interface fetch_pc_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int FETCH_N = 2
);
    localparam int CNT_W = $clog2(FETCH_N + 1);

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_pc;
    logic [CNT_W-1:0]  req_cnt;
    logic              req_epoch;

    modport master (
        output req_valid,
        output req_pc,
        output req_cnt,
        output req_epoch,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_pc,
        input  req_cnt,
        input  req_epoch,
        output req_ready
    );

endinterface

// File: rtl/fetch_pc_gen_line_clip.sv
// Slot count of a fetch group starting at a given line offset, clipped so the
// group stays inside one I-cache line.
module fetch_line_clip #(
    parameter  int FETCH_N    = 2,
    parameter  int LINE_BYTES = 32,
    localparam int OFF_W      = $clog2(LINE_BYTES),
    localparam int CNT_W      = $clog2(FETCH_N + 1)
) (
    input  logic [OFF_W-1:0] pc,
    output logic [CNT_W-1:0] cnt
);

    logic [OFF_W:0] rem_words;

    // Byte-exact remainder so a misaligned offset rounds down like (LINE-off)/4
    always_comb begin
        rem_words = ((OFF_W + 1)'(LINE_BYTES) - {1'b0, pc}) >> 2;
        if (rem_words > (OFF_W + 1)'(FETCH_N)) begin
            cnt = CNT_W'(FETCH_N);
        end else begin
            cnt = CNT_W'(rem_words);
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-address generator: one line-clipped fetch group per cycle, with
// flush/redirect steering, epoch tagging and AdEL detection on the target.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                FETCH_N    = 2,
    parameter int                LINE_BYTES = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DefaultResetPc)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              ibuffer_full,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_pc_gen_if.master    req,
    output logic              addr_err,
    output logic [ADDR_W-1:0] addr_err_pc
);

    localparam int CNT_W = $clog2(FETCH_N + 1);
    localparam int OFF_W = $clog2(LINE_BYTES);

    logic [ADDR_W-1:0] pc;
    logic              epoch;
    pc_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              steer;
    logic [ADDR_W-1:0] target;

    fetch_line_clip #(
        .FETCH_N    (FETCH_N),
        .LINE_BYTES (LINE_BYTES)
    ) u_clip (
        .pc  (pc[OFF_W-1:0]),
        .cnt (cnt)
    );

    always_comb begin
        req.req_valid = (state == RUN) && (stall != Stop) && !ibuffer_full
                        && !flush && !redirect && (rst != RstEnable);
        req.req_pc    = pc;
        req.req_cnt   = cnt;
        req.req_epoch = epoch;
    end

    // Flush outranks redirect; redirect is dropped while parked in ERR
    always_comb begin
        accept = req.req_valid && req.req_ready;
        steer  = flush || (redirect && (state == RUN));
        target = flush ? flush_pc : redirect_pc;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pc          <= RESET_PC;
            epoch       <= 1'b0;
            state       <= RUN;
            addr_err    <= 1'b0;
            addr_err_pc <= '0;
        end else if (steer) begin
            pc    <= target;
            epoch <= ~epoch;
            if (word_aligned(target[1:0])) begin
                state    <= RUN;
                addr_err <= 1'b0;
            end else begin
                state       <= ERR;
                addr_err    <= 1'b1;
                addr_err_pc <= target;
            end
        end else if (accept) begin
            pc <= pc + (ADDR_W'(cnt) << 2);
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed scenarios plus randomized
// traffic against a behavioural model, and a FETCH_N sweep (1, 4, 8).
module tb_fetch_pc_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        ibuffer_full = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] flush_pc = '0;
    logic [31:0] redirect_pc = '0;
    logic        addr_err;
    logic [31:0] addr_err_pc;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    fetch_pc_gen_if #(.ADDR_W(32), .FETCH_N(2)) rq();

    fetch_pc_gen #(.ADDR_W(32), .FETCH_N(2), .LINE_BYTES(32), .RESET_PC(32'hbfc00000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .ibuffer_full(ibuffer_full),
        .flush(flush), .flush_pc(flush_pc), .redirect(redirect), .redirect_pc(redirect_pc),
        .req(rq), .addr_err(addr_err), .addr_err_pc(addr_err_pc)
    );

    // Sweep instances share one redirect/ready stimulus
    logic        sw_redirect = 1'b0;
    logic [31:0] sw_tgt = '0;
    logic        sw_ready = 1'b1;
    logic        s1_err, s4_err, s8_err;
    logic [31:0] s1_epc, s4_epc, s8_epc;

    fetch_pc_gen_if #(.ADDR_W(32), .FETCH_N(1)) s1();
    fetch_pc_gen_if #(.ADDR_W(32), .FETCH_N(4)) s4();
    fetch_pc_gen_if #(.ADDR_W(32), .FETCH_N(8)) s8();
    assign s1.req_ready = sw_ready;
    assign s4.req_ready = sw_ready;
    assign s8.req_ready = sw_ready;

    fetch_pc_gen #(.ADDR_W(32), .FETCH_N(1), .LINE_BYTES(32)) dut_n1 (
        .clk(clk), .rst(rst), .stall(1'b0), .ibuffer_full(1'b0), .flush(1'b0), .flush_pc(32'h0),
        .redirect(sw_redirect), .redirect_pc(sw_tgt), .req(s1), .addr_err(s1_err), .addr_err_pc(s1_epc)
    );
    fetch_pc_gen #(.ADDR_W(32), .FETCH_N(4), .LINE_BYTES(32)) dut_n4 (
        .clk(clk), .rst(rst), .stall(1'b0), .ibuffer_full(1'b0), .flush(1'b0), .flush_pc(32'h0),
        .redirect(sw_redirect), .redirect_pc(sw_tgt), .req(s4), .addr_err(s4_err), .addr_err_pc(s4_epc)
    );
    fetch_pc_gen #(.ADDR_W(32), .FETCH_N(8), .LINE_BYTES(32)) dut_n8 (
        .clk(clk), .rst(rst), .stall(1'b0), .ibuffer_full(1'b0), .flush(1'b0), .flush_pc(32'h0),
        .redirect(sw_redirect), .redirect_pc(sw_tgt), .req(s8), .addr_err(s8_err), .addr_err_pc(s8_epc)
    );

    logic [31:0] sw_obs_pc  [3];
    logic [3:0]  sw_obs_cnt [3];
    logic        sw_obs_val [3];
    logic        sw_obs_ep  [3];
    assign sw_obs_pc[0]  = s1.req_pc;
    assign sw_obs_pc[1]  = s4.req_pc;
    assign sw_obs_pc[2]  = s8.req_pc;
    assign sw_obs_cnt[0] = 4'(s1.req_cnt);
    assign sw_obs_cnt[1] = 4'(s4.req_cnt);
    assign sw_obs_cnt[2] = 4'(s8.req_cnt);
    assign sw_obs_val[0] = s1.req_valid;
    assign sw_obs_val[1] = s4.req_valid;
    assign sw_obs_val[2] = s8.req_valid;
    assign sw_obs_ep[0]  = s1.req_epoch;
    assign sw_obs_ep[1]  = s4.req_epoch;
    assign sw_obs_ep[2]  = s8.req_epoch;

    logic [68:0] obs_vec;
    assign obs_vec = {rq.req_valid, rq.req_pc, rq.req_cnt, rq.req_epoch, addr_err, addr_err_pc};

    // Behavioural model state
    logic [31:0] m_pc = '0;
    logic [31:0] m_errpc = '0;
    logic        m_ep = 1'b0;
    logic        m_err = 1'b0;
    int unsigned sw_n [3] = '{1, 4, 8};
    logic [31:0] sw_m_pc [3];
    logic        sw_m_ep [3];

    function automatic int unsigned mcnt(input logic [31:0] pc, input int unsigned n);
        int unsigned r;
        r = (32 - int'(pc % 32)) / 4;
        return (r < n) ? r : n;
    endfunction

    function automatic logic exp_valid();
        return !m_err && !stall && !ibuffer_full && !flush && !redirect && !rst;
    endfunction

    function automatic logic [68:0] exp_vec();
        return {exp_valid(), m_pc, 2'(mcnt(m_pc, 2)), m_ep, m_err, m_errpc};
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom & 32'hfffffffc;
        if ($urandom_range(0, 2) == 0) t = (t & 32'hffffffe0) | 32'h1c;
        if ($urandom_range(0, 4) == 0) t = t | 32'($urandom_range(1, 3));
        return t;
    endfunction

    // Advance every model by one clock using the inputs currently applied
    task automatic tick();
        logic [31:0] npc, nerrpc, tgt;
        logic        nep, nerr;
        logic [31:0] snpc [3];
        logic        snep [3];
        npc = m_pc; nerrpc = m_errpc; nep = m_ep; nerr = m_err;
        if (rst) begin
            npc = 32'hbfc00000; nep = 1'b0; nerr = 1'b0; nerrpc = '0;
        end else if (flush || (redirect && !m_err)) begin
            tgt = flush ? flush_pc : redirect_pc;
            npc = tgt;
            nep = !m_ep;
            if (tgt % 4 == 0) nerr = 1'b0;
            else begin nerr = 1'b1; nerrpc = tgt; end
        end else if (exp_valid() && rq.req_ready) begin
            npc = m_pc + 32'(4 * mcnt(m_pc, 2));
        end
        for (int k = 0; k < 3; k++) begin
            snpc[k] = sw_m_pc[k]; snep[k] = sw_m_ep[k];
            if (rst) begin snpc[k] = 32'hbfc00000; snep[k] = 1'b0; end
            else if (sw_redirect) begin snpc[k] = sw_tgt; snep[k] = !sw_m_ep[k]; end
            else if (sw_ready) snpc[k] = sw_m_pc[k] + 32'(4 * mcnt(sw_m_pc[k], sw_n[k]));
        end
        @(posedge clk);
        m_pc = npc; m_errpc = nerrpc; m_ep = nep; m_err = nerr;
        for (int k = 0; k < 3; k++) begin sw_m_pc[k] = snpc[k]; sw_m_ep[k] = snep[k]; end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rq.req_ready = 1'b1;
        #1;
        vectors++;
        if (rq.req_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid obs=%b exp=0", rq.req_valid);
        end
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (obs_vec !== exp_vec()) begin
                miscompares++; $display("FAIL reset_seq obs=%h exp=%h", obs_vec, exp_vec());
            end
            vectors++;
            if (rq.req_pc !== 32'hbfc00000 + 32'(8 * i) || rq.req_cnt !== 2'd2 || rq.req_epoch !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_pc obs=%h/%0d/%b exp=%h/2/0", rq.req_pc, rq.req_cnt, rq.req_epoch, 32'hbfc00000 + 32'(8 * i));
            end
            tick();
        end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h8000001c;
        #1;
        vectors++;
        if (obs_vec !== exp_vec()) begin
            miscompares++; $display("FAIL redir_cycle obs=%h exp=%h", obs_vec, exp_vec());
        end
        tick();
        redirect = 1'b0;
        #1;
        vectors++;
        if (rq.req_pc !== 32'h8000001c || rq.req_epoch !== 1'b1 || rq.req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL redir_stalled obs=%h/%b/%b exp=8000001c/1/0", rq.req_pc, rq.req_epoch, rq.req_valid);
        end
        stall = 1'b0;
        #1;
        vectors++;
        if (rq.req_cnt !== 2'd1 || rq.req_valid !== 1'b1) begin
            miscompares++; $display("FAIL redir_clip obs=%0d/%b exp=1/1", rq.req_cnt, rq.req_valid);
        end
        vectors++;
        if (obs_vec !== exp_vec()) begin
            miscompares++; $display("FAIL redir_model obs=%h exp=%h", obs_vec, exp_vec());
        end
        tick();
        #1;
        vectors++;
        if (rq.req_pc !== 32'h80000020 || rq.req_cnt !== 2'd2) begin
            miscompares++; $display("FAIL redir_next obs=%h/%0d exp=80000020/2", rq.req_pc, rq.req_cnt);
        end
    endtask

    task automatic test_flush_redirect();
        logic ep0;
        ep0 = m_ep;
        flush = 1'b1; flush_pc = 32'hbfc00380; redirect = 1'b1; redirect_pc = 32'h80001000;
        #1;
        vectors++;
        if (rq.req_valid !== 1'b0) begin
            miscompares++; $display("FAIL both_valid obs=%b exp=0", rq.req_valid);
        end
        tick();
        flush = 1'b0; redirect = 1'b0;
        #1;
        vectors++;
        if (rq.req_pc !== 32'hbfc00380 || rq.req_epoch !== !ep0) begin
            miscompares++;
            $display("FAIL both_target obs=%h/%b exp=bfc00380/%b", rq.req_pc, rq.req_epoch, !ep0);
        end
        vectors++;
        if (obs_vec !== exp_vec()) begin
            miscompares++; $display("FAIL both_model obs=%h exp=%h", obs_vec, exp_vec());
        end
    endtask

    task automatic test_addr_err();
        redirect = 1'b1; redirect_pc = 32'h80000002;
        #1; tick();
        redirect = 1'b0;
        #1;
        vectors++;
        if (addr_err !== 1'b1 || addr_err_pc !== 32'h80000002 || rq.req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL adel_set obs=%b/%h/%b exp=1/80000002/0", addr_err, addr_err_pc, rq.req_valid);
        end
        redirect = 1'b1; redirect_pc = 32'h80000040;
        #1; tick();
        redirect = 1'b0;
        #1;
        vectors++;
        if (rq.req_pc !== 32'h80000002 || addr_err !== 1'b1) begin
            miscompares++; $display("FAIL adel_ignore obs=%h/%b exp=80000002/1", rq.req_pc, addr_err);
        end
        vectors++;
        if (obs_vec !== exp_vec()) begin
            miscompares++; $display("FAIL adel_model obs=%h exp=%h", obs_vec, exp_vec());
        end
        flush = 1'b1; flush_pc = 32'hbfc00380;
        #1; tick();
        flush = 1'b0;
        #1;
        vectors++;
        if (addr_err !== 1'b0 || rq.req_valid !== 1'b1 || rq.req_pc !== 32'hbfc00380) begin
            miscompares++;
            $display("FAIL adel_clear obs=%b/%b/%h exp=0/1/bfc00380", addr_err, rq.req_valid, rq.req_pc);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] p0;
        p0 = m_pc;
        rq.req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (rq.req_pc !== p0 || obs_vec !== exp_vec()) begin
                miscompares++; $display("FAIL bp_hold obs=%h exp=%h", obs_vec, exp_vec());
            end
            tick();
        end
        rq.req_ready = 1'b1;
        #1; tick();
        #1;
        vectors++;
        if (rq.req_pc !== p0 + 32'h8) begin
            miscompares++; $display("FAIL bp_advance obs=%h exp=%h", rq.req_pc, p0 + 32'h8);
        end
        ibuffer_full = 1'b1;
        #1;
        vectors++;
        if (rq.req_valid !== 1'b0) begin
            miscompares++; $display("FAIL ibuf_valid obs=%b exp=0", rq.req_valid);
        end
        tick();
        #1;
        vectors++;
        if (rq.req_pc !== p0 + 32'h8 || obs_vec !== exp_vec()) begin
            miscompares++; $display("FAIL ibuf_hold obs=%h exp=%h", obs_vec, exp_vec());
        end
        ibuffer_full = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            rst          = ($urandom_range(0, 49) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            ibuffer_full = ($urandom_range(0, 6) == 0);
            flush        = ($urandom_range(0, 15) == 0);
            redirect     = ($urandom_range(0, 9) == 0);
            flush_pc     = rand_target();
            redirect_pc  = rand_target();
            rq.req_ready = ($urandom_range(0, 9) < 7);
            #1;
            vectors++;
            if (obs_vec !== exp_vec()) begin
                miscompares++; $display("FAIL random[%0d] obs=%h exp=%h", i, obs_vec, exp_vec());
            end
            tick();
        end
        rst = 1'b0; stall = 1'b0; ibuffer_full = 1'b0; flush = 1'b0; redirect = 1'b0; rq.req_ready = 1'b1;
    endtask

    task automatic test_sweep();
        rst = 1'b1; sw_redirect = 1'b0; sw_ready = 1'b1;
        #1; tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (s8.req_pc !== 32'hbfc00000 + 32'(32 * i) || s8.req_cnt !== 4'd8) begin
                miscompares++;
                $display("FAIL sweep_n8 obs=%h/%0d exp=%h/8", s8.req_pc, s8.req_cnt, 32'hbfc00000 + 32'(32 * i));
            end
            tick();
        end
        for (int i = 0; i < 300; i++) begin
            sw_redirect = ($urandom_range(0, 7) == 0);
            sw_tgt      = $urandom & 32'hfffffffc;
            sw_ready    = ($urandom_range(0, 3) != 0);
            #1;
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (sw_obs_pc[k] !== sw_m_pc[k] || sw_obs_cnt[k] !== 4'(mcnt(sw_m_pc[k], sw_n[k]))
                    || sw_obs_ep[k] !== sw_m_ep[k] || sw_obs_val[k] !== !sw_redirect) begin
                    miscompares++;
                    $display("FAIL sweep_n%0d[%0d] obs=%h/%0d/%b/%b exp=%h/%0d/%b/%b", sw_n[k], i,
                             sw_obs_pc[k], sw_obs_cnt[k], sw_obs_ep[k], sw_obs_val[k],
                             sw_m_pc[k], mcnt(sw_m_pc[k], sw_n[k]), sw_m_ep[k], !sw_redirect);
                end
                vectors++;
                if (int'(sw_obs_pc[k] % 32) + 4 * int'(sw_obs_cnt[k]) > 32) begin
                    miscompares++;
                    $display("FAIL sweep_line n%0d obs=%h+%0d exp=within_line", sw_n[k], sw_obs_pc[k], sw_obs_cnt[k]);
                end
            end
            tick();
        end
        sw_redirect = 1'b0; sw_ready = 1'b1;
    endtask

    initial begin
        rq.req_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_redirect_stall();
        test_flush_redirect();
        test_addr_err();
        test_backpressure();
        test_random();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
